// File: rtl/touch_pkg.sv
// Shared definitions for the touch decoder slice.
//   - sensor code constants (TOUCH_NONE, TOUCH_S1..TOUCH_S4)
//   - event word layout: [EVT_PRESS_BIT] press/release, [EVT_IDX_MSB:0] sensor index
//   - event FIFO depth and debounce FSM state type
//   - helpers to build an event word and a one-hot key map from a code
package touch_pkg;

  localparam logic [2:0] TOUCH_NONE = 3'd0;
  localparam logic [2:0] TOUCH_S1   = 3'd1;
  localparam logic [2:0] TOUCH_S2   = 3'd2;
  localparam logic [2:0] TOUCH_S3   = 3'd3;
  localparam logic [2:0] TOUCH_S4   = 3'd4;

  localparam int EVT_PRESS_BIT   = 2;
  localparam int EVT_IDX_MSB     = 1;
  localparam int EVT_W           = EVT_PRESS_BIT + 1;
  localparam int TOUCH_EVT_DEPTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } deb_state_e;

  // Event word for a sensor code 1..4; the stored index is code-1.
  function automatic logic [EVT_W-1:0] make_evt(input logic press, input logic [2:0] code);
    logic [2:0] idx;
    idx = code - 3'd1;
    return {press, idx[EVT_IDX_MSB:0]};
  endfunction

  function automatic logic [3:0] code_to_onehot(input logic [2:0] code);
    logic [3:0] onehot;
    case (code)
      TOUCH_S1: onehot = 4'b0001;
      TOUCH_S2: onehot = 4'b0010;
      TOUCH_S3: onehot = 4'b0100;
      TOUCH_S4: onehot = 4'b1000;
      default:  onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/touch_evt_fifo.sv
// Event FIFO: TOUCH_EVT_DEPTH entries of EVT_W bits, up to two pushes and
// one pop per cycle.
//   clk, rst              : clock, synchronous active-high reset
//   push_vld[1:0]         : slot 0 / slot 1 push requests (slot 0 is older)
//   push_data0/push_data1 : event words for slot 0 / slot 1
//   pop_req               : consumer ready; pops the head when non-empty
//   head_vld, head_data   : head entry (head_data is 0 when empty)
//   drop                  : pulse, at least one push did not fit this cycle
module touch_evt_fifo
  import touch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       push_vld,
  input  logic [EVT_W-1:0] push_data0,
  input  logic [EVT_W-1:0] push_data1,
  input  logic             pop_req,
  output logic             head_vld,
  output logic [EVT_W-1:0] head_data,
  output logic             drop
);

  localparam int PTR_W = $clog2(TOUCH_EVT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [EVT_W-1:0] mem_q [TOUCH_EVT_DEPTH];
  logic [EVT_W-1:0] mem_d [TOUCH_EVT_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] wr_ptr1;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free;
  logic             pop, acc0, acc1;

  always_comb begin
    pop  = pop_req && (count_q != '0);
    // A same-cycle pop frees its slot for this cycle's pushes.
    free = CNT_W'(TOUCH_EVT_DEPTH) - count_q + CNT_W'(pop);
    // Slot 0 gets first claim on the space, so a release is kept over a press.
    acc0 = push_vld[0] && (free != '0);
    acc1 = push_vld[1] && (free > CNT_W'(acc0));
    drop = (push_vld[0] && !acc0) || (push_vld[1] && !acc1);

    wr_ptr1  = wr_ptr_q + PTR_W'(acc0);
    wr_ptr_d = wr_ptr_q + PTR_W'(acc0) + PTR_W'(acc1);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(pop);

    for (int i = 0; i < TOUCH_EVT_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (acc0 && (wr_ptr_q == PTR_W'(i))) begin
        mem_d[i] = push_data0;
      end else if (acc1 && (wr_ptr1 == PTR_W'(i))) begin
        mem_d[i] = push_data1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only visible through head_vld.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_vld  = (count_q != '0);
  assign head_data = head_vld ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/touch_decoder.sv
// Capacitive touch decoder: synchronizes a 4-bit sensor code, debounces it,
// presents a one-hot key map and queues press/release events.
//   clk, rst     : clock, synchronous active-high reset
//   code_in      : asynchronous sensor code (0 none, 1..4 sensor, 5..15 invalid)
//   key_state    : debounced one-hot key map
//   evt_valid    : event available; evt_data holds it
//   evt_ready    : consumer accepts the head event
//   evt_data     : [2] press(1)/release(0), [1:0] sensor index
//   evt_overflow : sticky, an event was dropped
//   invalid_seen : sticky, an invalid synchronized code occurred
module touch_decoder
  import touch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       code_in,
  output logic [3:0]       key_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EVT_W-1:0] evt_data,
  output logic             evt_overflow,
  output logic             invalid_seen
);

  localparam logic [7:0] ACCEPT_CNT = 8'(DEBOUNCE_CYCLES);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       code_s_q, code_s_d;
  logic [2:0]       cand_q, cand_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       stable_q, stable_d;
  deb_state_e       state_q, state_d;
  logic             invalid_q, invalid_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       code_m;
  logic             accept;
  logic [1:0]       push_vld;
  logic [EVT_W-1:0] push_data0, push_data1;
  logic             fifo_drop;

  always_comb begin
    sync1_d   = code_in;
    code_s_d  = sync1_q;
    invalid_d = invalid_q;
    if (code_s_q > 4'd4) begin
      code_m    = TOUCH_NONE;
      invalid_d = 1'b1;
    end else begin
      code_m = code_s_q[2:0];
    end

    // Candidate tracking: a new code reloads the candidate and restarts the
    // count; acceptance needs DEBOUNCE_CYCLES further matching cycles.
    cand_d = cand_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (code_m != cand_q) begin
      cand_d = code_m;
      cnt_d  = '0;
    end else begin
      accept = (cnt_q >= ACCEPT_CNT);
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    state_d    = state_q;
    stable_d   = stable_q;
    push_vld   = 2'b00;
    push_data0 = '0;
    push_data1 = '0;
    // Re-acceptance of the current stable code is a no-op.
    if (accept && (cand_q != stable_q)) begin
      stable_d = cand_q;
      state_d  = (cand_q == TOUCH_NONE) ? ST_IDLE : ST_HELD;
      if (state_q == ST_HELD && cand_q != TOUCH_NONE) begin
        push_vld   = 2'b11;
        push_data0 = make_evt(1'b0, stable_q);
        push_data1 = make_evt(1'b1, cand_q);
      end else if (state_q == ST_HELD) begin
        push_vld   = 2'b01;
        push_data0 = make_evt(1'b0, stable_q);
      end else begin
        push_vld   = 2'b01;
        push_data0 = make_evt(1'b1, cand_q);
      end
    end

    ovf_d = ovf_q | fifo_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      code_s_q  <= '0;
      cand_q    <= TOUCH_NONE;
      cnt_q     <= '0;
      stable_q  <= TOUCH_NONE;
      state_q   <= ST_IDLE;
      invalid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      code_s_q  <= code_s_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      state_q   <= state_d;
      invalid_q <= invalid_d;
      ovf_q     <= ovf_d;
    end
  end

  touch_evt_fifo u_evt_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (push_vld),
    .push_data0(push_data0),
    .push_data1(push_data1),
    .pop_req   (evt_ready),
    .head_vld  (evt_valid),
    .head_data (evt_data),
    .drop      (fifo_drop)
  );

  assign key_state    = code_to_onehot(stable_q);
  assign evt_overflow = ovf_q;
  assign invalid_seen = invalid_q;

endmodule

// File: tb/tb_touch_decoder.sv
// Directed bench for touch_decoder with DEBOUNCE_CYCLES=4.
// "Edge 0" is the first rising edge that samples a new code_in; the
// debounced result must appear after edge 7 and not after edge 6.
module tb_touch_decoder;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] code_in;
  logic [3:0] key_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_data;
  logic       evt_overflow;
  logic       invalid_seen;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  touch_decoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk         (clk),
    .rst         (rst),
    .code_in     (code_in),
    .key_state   (key_state),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .evt_overflow(evt_overflow),
    .invalid_seen(invalid_seen)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; code_in = 4'd0; evt_ready = 1'b1;
    tick(3);
    n_checks++; if ({key_state, evt_valid, evt_data, evt_overflow, invalid_seen} !== 10'b0) begin
      n_fail++; $display("FAIL reset_hold outputs=%b required=%b", {key_state, evt_valid, evt_data, evt_overflow, invalid_seen}, 10'b0);
    end
    rst = 1'b0;
    tick(1);
    n_checks++; if ({key_state, evt_valid, evt_data, evt_overflow, invalid_seen} !== 10'b0) begin
      n_fail++; $display("FAIL reset_release outputs=%b required=%b", {key_state, evt_valid, evt_data, evt_overflow, invalid_seen}, 10'b0);
    end
    tick(8);
    $display("test_reset done");
  endtask

  task automatic test_basic_press;
    code_in = 4'd2;
    tick(7);
    n_checks++; if (key_state !== 4'b0000 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL press_early key=%b valid=%b required key=0000 valid=0", key_state, evt_valid);
    end
    tick(1);
    n_checks++; if (key_state !== 4'b0010) begin
      n_fail++; $display("FAIL press_key key=%b required=0010", key_state);
    end
    n_checks++; if (evt_valid !== 1'b1 || evt_data !== 3'b101) begin
      n_fail++; $display("FAIL press_evt valid=%b data=%b required valid=1 data=101", evt_valid, evt_data);
    end
    $display("event press data=%b", evt_data);
    tick(1);
    n_checks++; if (evt_valid !== 1'b0 || evt_data !== 3'b000) begin
      n_fail++; $display("FAIL press_pop valid=%b data=%b required valid=0 data=000", evt_valid, evt_data);
    end
    code_in = 4'd0;
    tick(8);
    n_checks++; if (key_state !== 4'b0000 || evt_valid !== 1'b1 || evt_data !== 3'b001) begin
      n_fail++; $display("FAIL release_evt key=%b valid=%b data=%b required key=0000 valid=1 data=001", key_state, evt_valid, evt_data);
    end
    $display("event release data=%b", evt_data);
    tick(1);
  endtask

  task automatic test_glitch;
    code_in = 4'd3;
    tick(5);
    code_in = 4'd0;
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (key_state !== 4'b0000 || evt_valid !== 1'b0) begin
        n_fail++; $display("FAIL glitch cyc=%0d key=%b valid=%b required key=0000 valid=0", i, key_state, evt_valid);
      end
      tick(1);
    end
    $display("test_glitch done");
  endtask

  task automatic test_direct_change;
    code_in = 4'd1;
    tick(8);
    n_checks++; if (evt_valid !== 1'b1 || evt_data !== 3'b100) begin
      n_fail++; $display("FAIL s1_press valid=%b data=%b required valid=1 data=100", evt_valid, evt_data);
    end
    tick(1);
    code_in = 4'd4;
    tick(8);
    n_checks++; if (key_state !== 4'b1000) begin
      n_fail++; $display("FAIL direct_key key=%b required=1000", key_state);
    end
    n_checks++; if (evt_valid !== 1'b1 || evt_data !== 3'b000) begin
      n_fail++; $display("FAIL direct_release valid=%b data=%b required valid=1 data=000", evt_valid, evt_data);
    end
    $display("event release data=%b", evt_data);
    tick(1);
    n_checks++; if (evt_valid !== 1'b1 || evt_data !== 3'b111) begin
      n_fail++; $display("FAIL direct_press valid=%b data=%b required valid=1 data=111", evt_valid, evt_data);
    end
    $display("event press data=%b", evt_data);
    tick(1);
    n_checks++; if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL direct_empty valid=%b required=0", evt_valid);
    end
    code_in = 4'd0;
    tick(8);
    n_checks++; if (evt_valid !== 1'b1 || evt_data !== 3'b011) begin
      n_fail++; $display("FAIL s4_release valid=%b data=%b required valid=1 data=011", evt_valid, evt_data);
    end
    tick(1);
  endtask

  task automatic test_overflow;
    logic [2:0] exp_q [4];
    exp_q = '{3'b000, 3'b110, 3'b010, 3'b101};
    evt_ready = 1'b0;
    code_in = 4'd1; tick(8);
    code_in = 4'd3; tick(8);
    code_in = 4'd0; tick(8);
    n_checks++; if (evt_valid !== 1'b1 || evt_data !== 3'b100 || evt_overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_head valid=%b data=%b ovf=%b required valid=1 data=100 ovf=0", evt_valid, evt_data, evt_overflow);
    end
    // Full FIFO: a pop on the acceptance edge must make room for the press.
    code_in = 4'd2;
    tick(7);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    n_checks++; if (evt_overflow !== 1'b0 || evt_data !== 3'b000) begin
      n_fail++; $display("FAIL pop_frees_slot ovf=%b data=%b required ovf=0 data=000", evt_overflow, evt_data);
    end
    code_in = 4'd0;
    tick(8);
    n_checks++; if (evt_overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_flag ovf=%b required=1", evt_overflow);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (evt_valid !== 1'b1 || evt_data !== exp_q[i]) begin
        n_fail++; $display("FAIL drain_%0d valid=%b data=%b required valid=1 data=%b", i, evt_valid, evt_data, exp_q[i]);
      end
      $display("event drain %0d data=%b", i, evt_data);
      tick(1);
    end
    n_checks++; if (evt_valid !== 1'b0 || evt_overflow !== 1'b1) begin
      n_fail++; $display("FAIL drain_end valid=%b ovf=%b required valid=0 ovf=1", evt_valid, evt_overflow);
    end
  endtask

  task automatic test_invalid;
    n_checks++; if (invalid_seen !== 1'b0) begin
      n_fail++; $display("FAIL invalid_pre inv=%b required=0", invalid_seen);
    end
    code_in = 4'b1001;
    tick(12);
    n_checks++; if (invalid_seen !== 1'b1 || key_state !== 4'b0000 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL invalid_code inv=%b key=%b valid=%b required inv=1 key=0000 valid=0", invalid_seen, key_state, evt_valid);
    end
    code_in = 4'd0;
    tick(8);
    n_checks++; if (evt_valid !== 1'b0 || invalid_seen !== 1'b1) begin
      n_fail++; $display("FAIL invalid_after valid=%b inv=%b required valid=0 inv=1", evt_valid, invalid_seen);
    end
    $display("test_invalid done");
  endtask

  task automatic test_reset_mid;
    evt_ready = 1'b1;
    code_in = 4'd1; tick(9);
    evt_ready = 1'b0;
    code_in = 4'd2; tick(8);
    n_checks++; if (evt_valid !== 1'b1 || evt_data !== 3'b000 || key_state !== 4'b0010) begin
      n_fail++; $display("FAIL mid_setup valid=%b data=%b key=%b required valid=1 data=000 key=0010", evt_valid, evt_data, key_state);
    end
    rst = 1'b1;
    tick(1);
    n_checks++; if ({key_state, evt_valid, evt_data, evt_overflow, invalid_seen} !== 10'b0) begin
      n_fail++; $display("FAIL mid_reset outputs=%b required=%b", {key_state, evt_valid, evt_data, evt_overflow, invalid_seen}, 10'b0);
    end
    rst = 1'b0;
    tick(1);
    n_checks++; if ({key_state, evt_valid, evt_data, evt_overflow, invalid_seen} !== 10'b0) begin
      n_fail++; $display("FAIL mid_release outputs=%b required=%b", {key_state, evt_valid, evt_data, evt_overflow, invalid_seen}, 10'b0);
    end
    tick(6);
    n_checks++; if (key_state !== 4'b0000 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_early key=%b valid=%b required key=0000 valid=0", key_state, evt_valid);
    end
    tick(1);
    n_checks++; if (key_state !== 4'b0010 || evt_valid !== 1'b1 || evt_data !== 3'b101) begin
      n_fail++; $display("FAIL mid_repress key=%b valid=%b data=%b required key=0010 valid=1 data=101", key_state, evt_valid, evt_data);
    end
    $display("event re-press data=%b", evt_data);
    evt_ready = 1'b1;
    tick(1);
    n_checks++; if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_only_one valid=%b required=0", evt_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_press();
    test_glitch();
    test_direct_change();
    test_overflow();
    test_invalid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
